// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: digit-stream combination lock with fail lockout and auto-relock.
// Define COMBO_LOCK_PROG_EN to add a PROG port and a reprogrammable combination.
module combo_lock_ctrl #(
  parameter int DIGIT_W = 4,
  parameter int NUM_DIGITS = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] COMBO = 16'h8421,
  parameter int MAX_FAILS = 3,
  parameter int OPEN_CYCLES = 16,
  parameter int LOCKOUT_CYCLES = 64,
  parameter int ENTRY_TIMEOUT = 32
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [DIGIT_W-1:0] DIGIT,
  input  logic               DIGIT_VALID,
  input  logic               CLEAR,
`ifdef COMBO_LOCK_PROG_EN
  input  logic               PROG,
`endif
  output logic               OPEN,
  output logic               LOCKOUT,
  output logic               DIGIT_ACK,
  output logic               FAIL
);
  localparam int W = NUM_DIGITS * DIGIT_W;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int T1 = OPEN_CYCLES > LOCKOUT_CYCLES ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TMAX = T1 > ENTRY_TIMEOUT ? T1 : ENTRY_TIMEOUT;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_OPEN, S_LOCKED} state_t;

  state_t               state, state_n;
  logic [IW-1:0]        idx, idx_n;
  logic                 mis, mis_n;
  logic [FW-1:0]        fails, fails_n, fails_inc;
  logic [TW-1:0]        tmr, tmr_n;
  logic                 ack_n, fail_n, last, bad;
  logic [W-1:0]         combo;
  logic [DIGIT_W-1:0]   want;

`ifdef COMBO_LOCK_PROG_EN
  logic [W-1:0] combo_n, stage, stage_n;
`else
  assign combo = COMBO;
`endif

  assign want = combo[W - DIGIT_W * (int'(idx) + 1) +: DIGIT_W];
  assign last = idx == IW'(NUM_DIGITS - 1);
  assign bad = mis | (DIGIT != want);
  assign fails_inc = fails == FW'(MAX_FAILS) ? fails : fails + 1'b1;

  always_comb begin
    state_n = state;
    idx_n = idx;
    mis_n = mis;
    fails_n = fails;
    tmr_n = tmr;
    ack_n = 1'b0;
    fail_n = 1'b0;
`ifdef COMBO_LOCK_PROG_EN
    combo_n = combo;
    stage_n = stage;
`endif
    case (state)
      S_IDLE, S_ENTRY: begin
        if (CLEAR) begin
          state_n = S_IDLE;
          idx_n = '0;
          mis_n = 1'b0;
        end else if (DIGIT_VALID) begin
          ack_n = 1'b1;
          tmr_n = '0;
          state_n = S_ENTRY;
          idx_n = idx + 1'b1;
          mis_n = bad;
          if (last) begin
            idx_n = '0;
            mis_n = 1'b0;
            fail_n = bad;
            fails_n = bad ? fails_inc : '0;
            state_n = !bad ? S_OPEN : fails_inc == FW'(MAX_FAILS) ? S_LOCKED : S_IDLE;
          end
        end else if (state == S_ENTRY) begin
          tmr_n = tmr + 1'b1;
          if (tmr == TW'(ENTRY_TIMEOUT - 1)) begin
            state_n = S_IDLE;
            idx_n = '0;
            mis_n = 1'b0;
          end
        end
      end
      S_OPEN: begin
        if (CLEAR) begin
          state_n = S_IDLE;
          idx_n = '0;
        end
`ifdef COMBO_LOCK_PROG_EN
        else if (DIGIT_VALID && PROG) begin
          // idx doubles as the programming digit counter while open
          ack_n = 1'b1;
          stage_n = W'({stage, DIGIT});
          idx_n = last ? '0 : idx + 1'b1;
          if (last) begin
            combo_n = stage_n;
            state_n = S_IDLE;
          end
        end
`endif
        else if (OPEN_CYCLES != 0 && idx == '0) begin
          tmr_n = tmr + 1'b1;
          if (tmr == TW'(OPEN_CYCLES - 1)) state_n = S_IDLE;
        end
      end
      S_LOCKED: begin
        tmr_n = tmr + 1'b1;
        if (tmr == TW'(LOCKOUT_CYCLES - 1)) begin
          state_n = S_IDLE;
          fails_n = '0;
        end
      end
    endcase
    if (state_n != state) tmr_n = '0;
  end

  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= S_IDLE;
      idx <= '0;
      mis <= 1'b0;
      fails <= '0;
      tmr <= '0;
      OPEN <= 1'b0;
      LOCKOUT <= 1'b0;
      DIGIT_ACK <= 1'b0;
      FAIL <= 1'b0;
`ifdef COMBO_LOCK_PROG_EN
      combo <= COMBO;
      stage <= '0;
`endif
    end else begin
      state <= state_n;
      idx <= idx_n;
      mis <= mis_n;
      fails <= fails_n;
      tmr <= tmr_n;
      OPEN <= state_n == S_OPEN;
      LOCKOUT <= state_n == S_LOCKED;
      DIGIT_ACK <= ack_n;
      FAIL <= fail_n;
`ifdef COMBO_LOCK_PROG_EN
      combo <= combo_n;
      stage <= stage_n;
`endif
    end
endmodule

// File: doc/combo_lock_ctrl.md
# combo_lock_ctrl

Parametrised combination-lock controller and next-generation lock core for the board-level lock designs. It accepts a stream of pre-debounced, edge-detected digit strobes and compares a full NUM_DIGITS-long entry against the active combination. Only pass/fail is revealed, and only after the last digit, so no per-digit progress is visible. Failed attempts are counted toward a timed lockout, the lock relocks automatically, and combination reprogramming is an optional build feature.

## Interface
- DIGIT_W, 4: bits per digit
- NUM_DIGITS, 4: digits per combination; ≥1
- COMBO, 16'h8421: reset combination, NUM_DIGITS*DIGIT_W bits; first digit entered = most significant slice
- MAX_FAILS, 3: consecutive failed entries that trigger lockout; ≥1
- OPEN_CYCLES, 16: cycles OPEN stays high before auto-relock; 0 = no auto-relock
- LOCKOUT_CYCLES, 64: lockout duration in cycles; ≥1
- ENTRY_TIMEOUT, 32: idle cycles mid-entry before the partial entry is discarded; ≥1

Ports:
- CLK  in  1  single clock; all logic on posedge
- RESET_N  in  1  asynchronous, active-low reset
- DIGIT  in  DIGIT_W  digit value, sampled when DIGIT_VALID=1
- DIGIT_VALID  in  1  one-cycle digit strobe
- CLEAR  in  1  abandon entry / relock
- PROG  in  1  reprogram qualifier; present only with COMBO_LOCK_PROG_EN
- OPEN  out  1  lock open
- LOCKOUT  out  1  lockout active
- DIGIT_ACK  out  1  one-cycle pulse per accepted digit, independent of match
- FAIL  out  1  one-cycle pulse per completed wrong entry

## Operation
- States: IDLE, ENTRY, OPEN, LOCKED_OUT. Internal state: digit index idx (clog2 width), sticky mismatch flag, fail counter, and one shared timer.
- Reset: state=IDLE, idx=0, mismatch=0, fail count=0, timer=0, active combo=COMBO, all outputs 0.
- IDLE/ENTRY, accepted digit:
  - Compare DIGIT with combo slice idx, OR the result into mismatch, increment idx, pulse DIGIT_ACK.
  - IDLE→ENTRY on the first digit.
  - On digit NUM_DIGITS (mismatch included):
    - Match → OPEN, fail count cleared.
    - Mismatch → FAIL pulse, fail count +1; if it reaches MAX_FAILS → LOCKED_OUT, else → IDLE.
  - idx and mismatch are cleared on every completed entry.
- A wrong digit never aborts the entry early. Fail is decided only after all NUM_DIGITS digits.
- ENTRY timeout: ENTRY_TIMEOUT cycles with no DIGIT_VALID → IDLE, entry discarded, fail count unchanged.
- CLEAR:
  - ENTRY → IDLE, no fail counted.
  - OPEN → IDLE.
  - Ignored in IDLE and LOCKED_OUT.
- OPEN:
  - Timer counts OPEN_CYCLES, then → IDLE.
  - DIGIT_VALID is ignored, no ACK (except in PROG mode).
- LOCKED_OUT:
  - Timer counts LOCKOUT_CYCLES, then → IDLE with fail count cleared.
  - DIGIT_VALID is ignored, no ACK.
- Simultaneous CLEAR and DIGIT_VALID: CLEAR wins, digit dropped, no ACK.
- Timer is clog2 of the largest timing parameter and reloads on every state change; no wrap.
- Fail counter saturates at MAX_FAILS.

## Timing
- All outputs are registered.
- DIGIT_ACK is high in the cycle after the edge that samples DIGIT_VALID.
- OPEN or FAIL/LOCKOUT asserts in the cycle after the edge sampling the final digit.
- OPEN stays high exactly OPEN_CYCLES cycles; LOCKOUT stays high exactly LOCKOUT_CYCLES cycles.
- Back-to-back DIGIT_VALID on consecutive cycles are all accepted.
- RESET_N low mid-operation clears everything immediately, without waiting for a clock edge. Outputs are 0 while reset is held.

## Configuration
- COMBO_LOCK_PROG_EN defined:
  - PROG port exists and the active combo is a register.
  - In OPEN, DIGIT_VALID with PROG=1 is accepted (ACK pulses) and shifted into a staging register. The auto-relock timer is held during this.
  - After NUM_DIGITS such digits, the staging register becomes the active combo and the lock goes to IDLE.
  - CLEAR or a reset discards a partial program. Reset restores COMBO.
- COMBO_LOCK_PROG_EN undefined: no PROG port, and the combination is the constant COMBO.

## Test plan
- Digits 8,4,2,1 on consecutive cycles → DIGIT_ACK ×4; OPEN high for exactly 16 cycles; then IDLE.
- Digits 8,0,2,1 → 4 ACKs; FAIL pulse after the fourth digit only; OPEN=0; LOCKOUT=0.
- Three wrong entries → third FAIL plus LOCKOUT high for exactly 64 cycles. Digits 8,4,2,1 during lockout → no ACK, no OPEN. After lockout, 8,4,2,1 → OPEN.
- Digits 8,4, then 32 idle cycles, then 2,1 → no OPEN and no FAIL; fail count unchanged.
- CLEAR and DIGIT_VALID in the same cycle during ENTRY → no ACK; entry restarts. CLEAR while OPEN → OPEN drops the next cycle.
- With COMBO_LOCK_PROG_EN: open with 8421, PROG digits 1,2,3,4 → IDLE; 8,4,2,1 → FAIL; 1,2,3,4 → OPEN; RESET_N pulse → 8,4,2,1 opens again.
